// File: rtl/dac_sample_feeder_pkg.sv
// Shared types and widths for the DAC sample feeder and its record-path siblings.
package dac_feeder_pkg;

    localparam int DAC_SAMPLE_W = 12;
    localparam int CNT_W        = 16;

    typedef enum logic [1:0] {
        FEED_IDLE        = 2'd0,
        FEED_WAIT_ACCEPT = 2'd1,
        FEED_WAIT_DONE   = 2'd2
    } feed_state_t;

    // Debug counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dac_sample_feeder_if.sv
// Sample stream in and DAC-writer handshake out, bundled for the feeder.
interface dac_sample_feeder_if;
    import dac_feeder_pkg::*;

    logic [DAC_SAMPLE_W-1:0] s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [DAC_SAMPLE_W-1:0] dac_value;
    logic                    dac_enable;
    logic                    dac_busy;

    // slave is the feeder's view; master is the sample source plus DAC writer.
    modport slave  (input  s_data, s_valid, dac_busy,
                    output s_ready, dac_value, dac_enable);
    modport master (output s_data, s_valid, dac_busy,
                    input  s_ready, dac_value, dac_enable);
endinterface

// File: rtl/dac_sample_feeder_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and a flush that drops same-cycle traffic.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Full is taken from the registered level, so a same-cycle pop never frees a slot early.
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Buffers samples and hands one to the I2C DAC writer per rate tick, pacing on its busy flag.
module dac_sample_feeder
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int ACCEPT_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   flush,
    input  logic [15:0]            rate_div,
    dac_sample_feeder_if.slave     bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       underrun_count,
    output logic [CNT_W-1:0]       late_count,
    output logic [CNT_W-1:0]       timeout_count
);
    localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);

    logic [15:0]             tick_cnt;
    logic                    tick;
    logic                    pending;
    feed_state_t             state;
    feed_state_t             state_next;
    logic [TW-1:0]           wait_cnt;
    logic [TW-1:0]           wait_cnt_next;
    logic                    enable_next;
    logic [DAC_SAMPLE_W-1:0] value_next;
    logic [DAC_SAMPLE_W-1:0] head;
    logic                    pop;
    logic                    consume;
    logic                    underrun_inc;
    logic                    timeout_inc;
    logic                    fifo_full;
    logic                    fifo_empty;

    sync_fifo #(.WIDTH(DAC_SAMPLE_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .wr_en   (bus.s_valid),
        .wr_data (bus.s_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign bus.s_ready = !fifo_full;

    // Comparing with >= lets a shrunken rate_div fire on the very next cycle.
    assign tick = run && (tick_cnt >= rate_div);

    always_ff @(posedge clk) begin
        if (rst || !run || tick) tick_cnt <= '0;
        else                     tick_cnt <= tick_cnt + 1'b1;
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        enable_next   = bus.dac_enable;
        value_next    = bus.dac_value;
        pop           = 1'b0;
        consume       = 1'b0;
        underrun_inc  = 1'b0;
        timeout_inc   = 1'b0;
        case (state)
            FEED_IDLE: begin
                // A flush owns the cycle: it clears pending, so no handoff or underrun starts.
                if (pending && !flush) begin
                    if (!fifo_empty && !bus.dac_busy) begin
                        pop           = 1'b1;
                        consume       = 1'b1;
                        value_next    = head;
                        enable_next   = 1'b1;
                        wait_cnt_next = '0;
                        state_next    = FEED_WAIT_ACCEPT;
                    end else if (fifo_empty) begin
                        consume      = 1'b1;
                        underrun_inc = 1'b1;
                    end
                end
            end
            FEED_WAIT_ACCEPT: begin
                if (bus.dac_busy) begin
                    enable_next = 1'b0;
                    state_next  = FEED_WAIT_DONE;
                end else if (wait_cnt == TW'(ACCEPT_TIMEOUT - 1)) begin
                    enable_next = 1'b0;
                    timeout_inc = 1'b1;
                    state_next  = FEED_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            FEED_WAIT_DONE: begin
                if (!bus.dac_busy) state_next = FEED_IDLE;
            end
            default: state_next = FEED_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FEED_IDLE;
            wait_cnt       <= '0;
            bus.dac_enable <= 1'b0;
            bus.dac_value  <= '0;
            pending        <= 1'b0;
            underrun_count <= '0;
            late_count     <= '0;
            timeout_count  <= '0;
        end else begin
            state          <= state_next;
            wait_cnt       <= wait_cnt_next;
            bus.dac_enable <= enable_next;
            bus.dac_value  <= value_next;
            if (underrun_inc) underrun_count <= sat_inc(underrun_count);
            if (timeout_inc)  timeout_count  <= sat_inc(timeout_count);
            // A tick that lands on the consuming cycle re-arms pending without counting as late.
            if (flush) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
                if (pending && !consume) late_count <= sat_inc(late_count);
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scenario bench for dac_sample_feeder with a behavioural DAC-writer model and sample scoreboard.
module tb_dac_sample_feeder;
    import dac_feeder_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        flush;
    logic [15:0] rate_div;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0] underrun_count;
    logic [15:0] late_count;
    logic [15:0] timeout_count;

    int checks   = 0;
    int failures = 0;

    dac_sample_feeder_if bus();

    dac_sample_feeder #(.DEPTH(DEPTH), .ACCEPT_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .flush          (flush),
        .rate_div       (rate_div),
        .bus            (bus),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count),
        .late_count     (late_count),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    // DAC writer model: raises busy accept_delay cycles into an enable and holds it busy_len cycles.
    int          accept_delay = 2;
    int          busy_len     = 40;
    bit          never_busy   = 1'b0;
    logic [11:0] captured[$];
    logic [11:0] sent[$];
    int          pulses, overlap_errs, stab_errs, last_hi, falls, hi_cycles, acc_cnt, busy_left;
    logic        prev_en;
    logic [11:0] prev_val;

    initial begin
        bus.dac_busy = 1'b0;
        prev_en = 1'b0; prev_val = '0;
        pulses = 0; overlap_errs = 0; stab_errs = 0; last_hi = 0; falls = 0;
        hi_cycles = 0; acc_cnt = 0; busy_left = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                captured.delete();
                bus.dac_busy = 1'b0;
                prev_en = 1'b0; prev_val = '0;
                pulses = 0; overlap_errs = 0; stab_errs = 0; last_hi = 0; falls = 0;
                hi_cycles = 0; acc_cnt = 0; busy_left = 0;
            end else begin
                if (bus.dac_enable && !prev_en) begin
                    captured.push_back(bus.dac_value);
                    pulses++;
                    if (bus.dac_busy) overlap_errs++;
                    hi_cycles = 0;
                end
                if (bus.dac_enable) begin
                    hi_cycles++;
                    if (prev_en && bus.dac_value !== prev_val) stab_errs++;
                end
                if (!bus.dac_enable && prev_en) begin
                    last_hi = hi_cycles;
                    falls++;
                end
                if (bus.dac_busy) begin
                    busy_left--;
                    if (busy_left <= 0) bus.dac_busy = 1'b0;
                end else if (bus.dac_enable && !never_busy) begin
                    acc_cnt++;
                    if (acc_cnt >= accept_delay) begin
                        bus.dac_busy = 1'b1;
                        busy_left = busy_len;
                        acc_cnt = 0;
                    end
                end else begin
                    acc_cnt = 0;
                end
                prev_en  = bus.dac_enable;
                prev_val = bus.dac_value;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; flush = 1'b0; rate_div = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        sent.delete();
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic push_value(input logic [11:0] v);
        bus.s_valid = 1'b1;
        bus.s_data  = v;
        sent.push_back(v);
        step(1);
        bus.s_valid = 1'b0;
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push_value(12'($urandom_range(0, 4095)));
    endtask

    task automatic wait_captured(input int n, input int budget, output bit ok);
        ok = (captured.size() >= n);
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            ok = (captured.size() >= n);
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = !bus.dac_enable && !bus.dac_busy;
        for (int i = 0; i < budget && !ok; i++) begin
            step(1);
            ok = !bus.dac_enable && !bus.dac_busy;
        end
    endtask

    function automatic int order_errors();
        int bad = 0;
        if (captured.size() != sent.size()) bad++;
        for (int i = 0; i < captured.size() && i < sent.size(); i++)
            if (captured[i] !== sent[i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
        checks++; if (bus.dac_enable !== 1'b0) begin failures++; $display("[TB] FAIL reset_enable: got %b expected 0", bus.dac_enable); end
        checks++; if (bus.dac_value !== 12'h000) begin failures++; $display("[TB] FAIL reset_value: got %h expected 000", bus.dac_value); end
        checks++; if (fifo_level !== '0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (underrun_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_underrun: got %0d expected 0", underrun_count); end
        checks++; if (late_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_late: got %0d expected 0", late_count); end
        checks++; if (timeout_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_timeout: got %0d expected 0", timeout_count); end
    endtask

    task automatic test_basic_handoff();
        bit ok;
        do_reset();
        never_busy = 1'b0; accept_delay = 2; busy_len = 40;
        push_value(12'h123);
        push_value(12'hABC);
        rate_div = 16'd9;
        run = 1'b1;
        wait_captured(2, 300, ok);
        run = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL basic_wait: got %0d handoffs expected 2", captured.size()); end
        wait_idle(100, ok);
        step(3);
        checks++; if (pulses !== 2) begin failures++; $display("[TB] FAIL basic_pulses: got %0d expected 2", pulses); end
        checks++; if (order_errors() != 0) begin failures++; $display("[TB] FAIL basic_order: got %0d bad samples expected 0 (first %h)", order_errors(), bus.dac_value); end
        checks++; if (underrun_count !== 16'd0) begin failures++; $display("[TB] FAIL basic_underrun: got %0d expected 0", underrun_count); end
        checks++; if (stab_errs != 0) begin failures++; $display("[TB] FAIL basic_stable: got %0d value changes expected 0", stab_errs); end
        checks++; if (bus.dac_value !== 12'hABC) begin failures++; $display("[TB] FAIL basic_last_value: got %h expected abc", bus.dac_value); end
    endtask

    task automatic test_underrun();
        int run_cycles;
        do_reset();
        run_cycles = 50;
        rate_div = 16'd4;
        run = 1'b1;
        step(run_cycles);
        run = 1'b0;
        step(5);
        checks++; if (pulses !== 0) begin failures++; $display("[TB] FAIL underrun_pulses: got %0d expected 0", pulses); end
        checks++; if (underrun_count !== 16'(run_cycles / (int'(rate_div) + 1))) begin failures++; $display("[TB] FAIL underrun_count: got %0d expected %0d", underrun_count, run_cycles / (int'(rate_div) + 1)); end
        checks++; if (bus.dac_value !== 12'h000) begin failures++; $display("[TB] FAIL underrun_value: got %h expected 000", bus.dac_value); end
        checks++; if (late_count !== 16'd0) begin failures++; $display("[TB] FAIL underrun_late: got %0d expected 0", late_count); end
    endtask

    task automatic test_full_fifo();
        bit ok;
        do_reset();
        push_random(DEPTH);
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_s_ready: got %b expected 0", bus.s_ready); end
        checks++; if (fifo_level !== DEPTH) begin failures++; $display("[TB] FAIL full_level: got %0d expected %0d", fifo_level, DEPTH); end
        bus.s_valid = 1'b1;
        bus.s_data  = 12'($urandom_range(0, 4095));
        step(1);
        bus.s_valid = 1'b0;
        checks++; if (fifo_level !== DEPTH) begin failures++; $display("[TB] FAIL full_refused: got level %0d expected %0d", fifo_level, DEPTH); end
        never_busy   = 1'b0;
        accept_delay = $urandom_range(1, 4);
        busy_len     = $urandom_range(2, 12);
        rate_div     = 16'($urandom_range(2, 6));
        run = 1'b1;
        wait_captured(DEPTH, 2000, ok);
        run = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL full_drain_wait: got %0d handoffs expected %0d", captured.size(), DEPTH); end
        wait_idle(100, ok);
        step(3);
        checks++; if (order_errors() != 0) begin failures++; $display("[TB] FAIL full_order: got %0d bad samples expected 0", order_errors()); end
        checks++; if (captured.size() != DEPTH) begin failures++; $display("[TB] FAIL full_count: got %0d handoffs expected %0d", captured.size(), DEPTH); end
        checks++; if (fifo_level !== '0) begin failures++; $display("[TB] FAIL full_drained_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_late_ticks();
        bit ok;
        do_reset();
        never_busy = 1'b0; accept_delay = 2; busy_len = 40;
        push_random(4);
        rate_div = 16'd3;
        run = 1'b1;
        wait_captured(4, 1000, ok);
        run = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL late_wait: got %0d handoffs expected 4", captured.size()); end
        wait_idle(100, ok);
        checks++; if (late_count == 16'd0) begin failures++; $display("[TB] FAIL late_count: got %0d expected nonzero", late_count); end
        checks++; if (overlap_errs != 0) begin failures++; $display("[TB] FAIL late_pacing: got %0d enables during busy expected 0", overlap_errs); end
        checks++; if (order_errors() != 0) begin failures++; $display("[TB] FAIL late_order: got %0d bad samples expected 0", order_errors()); end
        checks++; if (pulses !== 4) begin failures++; $display("[TB] FAIL late_pulses: got %0d expected 4", pulses); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        never_busy = 1'b1;
        push_random(1);
        rate_div = 16'd2;
        run = 1'b1;
        wait_captured(1, 50, ok);
        run = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL timeout_wait: got %0d handoffs expected 1", captured.size()); end
        for (int i = 0; i < 50 && falls < 1; i++) step(1);
        checks++; if (falls < 1) begin failures++; $display("[TB] FAIL timeout_fall: got %0d enable falls expected 1", falls); end
        checks++; if (last_hi != TIMEOUT) begin failures++; $display("[TB] FAIL timeout_enable_cycles: got %0d expected %0d", last_hi, TIMEOUT); end
        checks++; if (timeout_count !== 16'd1) begin failures++; $display("[TB] FAIL timeout_count: got %0d expected 1", timeout_count); end
        checks++; if (fifo_level !== '0) begin failures++; $display("[TB] FAIL timeout_level: got %0d expected 0", fifo_level); end
        never_busy = 1'b0; accept_delay = 1; busy_len = 3;
        push_random(1);
        run = 1'b1;
        wait_captured(2, 100, ok);
        run = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL timeout_recover: got %0d handoffs expected 2", captured.size()); end
        wait_idle(50, ok);
        checks++; if (order_errors() != 0) begin failures++; $display("[TB] FAIL timeout_order: got %0d bad samples expected 0", order_errors()); end
        checks++; if (timeout_count !== 16'd1) begin failures++; $display("[TB] FAIL timeout_count_after: got %0d expected 1", timeout_count); end
    endtask

    task automatic test_flush_reset();
        bit ok;
        do_reset();
        rate_div = 16'd0;
        run = 1'b1;
        step(4);
        run = 1'b0;
        step(2);
        checks++; if (underrun_count !== 16'd4) begin failures++; $display("[TB] FAIL flush_pre_underrun: got %0d expected 4", underrun_count); end
        push_random(5);
        checks++; if (fifo_level !== 5) begin failures++; $display("[TB] FAIL flush_pre_level: got %0d expected 5", fifo_level); end
        flush = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 12'($urandom_range(0, 4095));
        step(1);
        flush = 1'b0;
        bus.s_valid = 1'b0;
        sent.delete();
        checks++; if (fifo_level !== '0) begin failures++; $display("[TB] FAIL flush_level: got %0d expected 0", fifo_level); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_s_ready: got %b expected 1", bus.s_ready); end
        never_busy = 1'b1;
        push_random(2);
        run = 1'b1;
        wait_captured(1, 20, ok);
        run = 1'b0;
        checks++; if (!ok) begin failures++; $display("[TB] FAIL flush_handoff_wait: got %0d handoffs expected 1", captured.size()); end
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        checks++; if (bus.dac_enable !== 1'b1) begin failures++; $display("[TB] FAIL flush_keeps_enable: got %b expected 1", bus.dac_enable); end
        checks++; if (fifo_level !== '0) begin failures++; $display("[TB] FAIL flush_inflight_level: got %0d expected 0", fifo_level); end
        checks++; if (bus.dac_value !== sent[0]) begin failures++; $display("[TB] FAIL flush_value_hold: got %h expected %h", bus.dac_value, sent[0]); end
        rst = 1'b1;
        step(1);
        checks++; if (bus.dac_enable !== 1'b0) begin failures++; $display("[TB] FAIL midreset_enable: got %b expected 0", bus.dac_enable); end
        checks++; if (bus.dac_value !== 12'h000) begin failures++; $display("[TB] FAIL midreset_value: got %h expected 000", bus.dac_value); end
        checks++; if (underrun_count !== 16'd0 || late_count !== 16'd0 || timeout_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL midreset_counters: got %0d/%0d/%0d expected 0/0/0", underrun_count, late_count, timeout_count);
        end
        checks++; if (fifo_level !== '0) begin failures++; $display("[TB] FAIL midreset_level: got %0d expected 0", fifo_level); end
        rst = 1'b0;
        never_busy = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_basic_handoff();
        test_underrun();
        test_full_fifo();
        test_late_ticks();
        test_timeout();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
